pipe_intr_id_exe_reg_fpu: RTL and testbench

Pipeline register between the ID stage and the EXE stage of the interrupt/FPU-capable 5-stage MIPS pipeline. It captures decoded control, operands, immediate, destination register and exception context (instruction PC, delay-slot flag) each cycle. It turns load-use stalls into EXE bubbles and flushes a cancelled instruction on exception or interrupt. It feeds the EXE stage directly; every e* output keeps the name the EXE stage consumes.

---
 rtl/pipe_intr_id_exe_reg_fpu.sv | 105 ++++++++++
 tb/tb_pipe_intr_id_exe_reg_fpu.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_intr_id_exe_reg_fpu.sv
// ID/EXE pipeline register for the interrupt/FPU MIPS pipeline.
// Stall or cancel turn the slot into a bubble; datapath fields always load.
module pipe_intr_id_exe_reg_fpu #(
  parameter int            DW     = 32,
  parameter logic [DW-1:0] RST_PC = '0
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          stall,
  input  logic          cancel,
  input  logic          dwreg,
  input  logic          dm2reg,
  input  logic          dwmem,
  input  logic          djal,
  input  logic          daluimm,
  input  logic          dshift,
  input  logic          darith,
  input  logic          dfwdfe,
  input  logic          dbd,
  input  logic [1:0]    dmfc0,
  input  logic          dmtc0,
  input  logic [3:0]    daluc,
  input  logic [DW-1:0] dpc4,
  input  logic [DW-1:0] dpc,
  input  logic [DW-1:0] dda,
  input  logic [DW-1:0] ddb,
  input  logic [DW-1:0] dimm,
  input  logic [4:0]    drn,
  output logic          ewreg0,
  output logic          em2reg,
  output logic          ewmem,
  output logic          ejal,
  output logic          ealuimm,
  output logic          eshift,
  output logic          earith,
  output logic          efwdfe,
  output logic          ebd,
  output logic          emtc0,
  output logic [1:0]    emfc0,
  output logic [3:0]    ealuc,
  output logic [DW-1:0] epc4,
  output logic [DW-1:0] epc,
  output logic [DW-1:0] eda,
  output logic [DW-1:0] edb,
  output logic [DW-1:0] eimm,
  output logic [4:0]    ern0,
  output logic          evalid
);

  logic          kill;
  logic [10:0]   ctl_d, ctl_q;
  logic          aluimm_q, shift_q;
  logic [3:0]    aluc_q;
  logic [4:0]    rn_q;
  logic [DW-1:0] pc4_q, pc_q, da_q, db_q, imm_q;

  // Side-effecting controls are zeroed in a bubble, incl. earith so
  // no overflow trap can come from a non-instruction.
  always_comb begin
    kill  = cancel | stall;
    ctl_d = {dwreg, dm2reg, dwmem, djal, dmtc0,
             darith, dfwdfe, dbd, dmfc0, 1'b1};
    if (kill) ctl_d = '0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ctl_q    <= '0;
      aluimm_q <= 1'b0;
      shift_q  <= 1'b0;
      aluc_q   <= '0;
      rn_q     <= '0;
      pc4_q    <= RST_PC;
      pc_q     <= RST_PC;
      da_q     <= '0;
      db_q     <= '0;
      imm_q    <= '0;
    end else begin
      ctl_q    <= ctl_d;
      aluimm_q <= daluimm;
      shift_q  <= dshift;
      aluc_q   <= daluc;
      rn_q     <= drn;
      pc4_q    <= dpc4;
      pc_q     <= dpc;
      da_q     <= dda;
      db_q     <= ddb;
      imm_q    <= dimm;
    end
  end

  assign {ewreg0, em2reg, ewmem, ejal, emtc0,
          earith, efwdfe, ebd, emfc0, evalid} = ctl_q;

  assign ealuimm = aluimm_q;
  assign eshift  = shift_q;
  assign ealuc   = aluc_q;
  assign ern0    = rn_q;
  assign epc4    = pc4_q;
  assign epc     = pc_q;
  assign eda     = da_q;
  assign edb     = db_q;
  assign eimm    = imm_q;

endmodule

// File: tb/tb_pipe_intr_id_exe_reg_fpu.sv
// Directed bench for pipe_intr_id_exe_reg_fpu.
// Table of per-edge vectors plus hand-written reset sequences.
module tb_pipe_intr_id_exe_reg_fpu;

  localparam logic L0 = 1'b0;
  localparam logic L1 = 1'b1;

  logic        clk = 1'b0;
  logic        clrn;
  logic        stall, cancel;
  logic        dwreg, dm2reg, dwmem, djal, daluimm, dshift;
  logic        darith, dfwdfe, dbd, dmtc0;
  logic [1:0]  dmfc0;
  logic [3:0]  daluc;
  logic [31:0] dpc4, dpc, dda, ddb, dimm;
  logic [4:0]  drn;
  logic        ewreg0, em2reg, ewmem, ejal, ealuimm, eshift;
  logic        earith, efwdfe, ebd, emtc0, evalid;
  logic [1:0]  emfc0;
  logic [3:0]  ealuc;
  logic [31:0] epc4, epc, eda, edb, eimm;
  logic [4:0]  ern0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_intr_id_exe_reg_fpu #(.DW(32), .RST_PC(32'h0)) dut (
    .clk(clk), .clrn(clrn), .stall(stall), .cancel(cancel),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .djal(djal),
    .daluimm(daluimm), .dshift(dshift), .darith(darith),
    .dfwdfe(dfwdfe), .dbd(dbd), .dmfc0(dmfc0), .dmtc0(dmtc0),
    .daluc(daluc), .dpc4(dpc4), .dpc(dpc), .dda(dda), .ddb(ddb),
    .dimm(dimm), .drn(drn),
    .ewreg0(ewreg0), .em2reg(em2reg), .ewmem(ewmem), .ejal(ejal),
    .ealuimm(ealuimm), .eshift(eshift), .earith(earith),
    .efwdfe(efwdfe), .ebd(ebd), .emtc0(emtc0), .emfc0(emfc0),
    .ealuc(ealuc), .epc4(epc4), .epc(epc), .eda(eda), .edb(edb),
    .eimm(eimm), .ern0(ern0), .evalid(evalid)
  );

  typedef struct {
    logic        stall, cancel, wreg, m2reg, wmem, mtc0, arith, bd;
    logic [1:0]  mfc0;
    logic [3:0]  aluc;
    logic [4:0]  rn;
    logic [31:0] pc, da, db;
  } vin_t;

  typedef struct {
    logic        wreg, m2reg, wmem, mtc0, arith, bd;
    logic [1:0]  mfc0;
    logic        valid;
    logic [3:0]  aluc;
    logic [4:0]  rn;
    logic [31:0] pc, da, db;
  } vexp_t;

  typedef struct {
    vin_t  i;
    vexp_t e;
  } vec_t;

  vec_t tv[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_all(input logic v);
    stall = 1'b0; cancel = 1'b0;
    dwreg = v; dm2reg = v; dwmem = v; djal = v; daluimm = v;
    dshift = v; darith = v; dfwdfe = v; dbd = v; dmtc0 = v;
    dmfc0 = {v, v}; daluc = {4{v}}; drn = {5{v}};
    dpc4 = {32{v}}; dpc = {32{v}}; dda = {32{v}};
    ddb = {32{v}}; dimm = {32{v}};
  endtask

  task automatic apply(input vin_t x);
    stall = x.stall; cancel = x.cancel;
    dwreg = x.wreg; dm2reg = x.m2reg; dwmem = x.wmem;
    dmtc0 = x.mtc0; darith = x.arith; dbd = x.bd;
    dmfc0 = x.mfc0; daluc = x.aluc; drn = x.rn;
    dpc = x.pc; dda = x.da; ddb = x.db;
    djal = 1'b1; dfwdfe = 1'b1; daluimm = 1'b1; dshift = 1'b1;
    dpc4 = x.pc + 32'd4;
    dimm = x.da ^ x.db;
  endtask

  task automatic check_vec(input int n, input vin_t x, input vexp_t e);
    string s;
    s = $sformatf("v%0d", n);
    chk({s, ".ewreg0"}, 32'(ewreg0), 32'(e.wreg));
    chk({s, ".em2reg"}, 32'(em2reg), 32'(e.m2reg));
    chk({s, ".ewmem"},  32'(ewmem),  32'(e.wmem));
    chk({s, ".emtc0"},  32'(emtc0),  32'(e.mtc0));
    chk({s, ".earith"}, 32'(earith), 32'(e.arith));
    chk({s, ".ebd"},    32'(ebd),    32'(e.bd));
    chk({s, ".emfc0"},  32'(emfc0),  32'(e.mfc0));
    chk({s, ".evalid"}, 32'(evalid), 32'(e.valid));
    chk({s, ".ejal"},   32'(ejal),   32'(e.valid));
    chk({s, ".efwdfe"}, 32'(efwdfe), 32'(e.valid));
    chk({s, ".ealuimm"}, 32'(ealuimm), 32'd1);
    chk({s, ".eshift"}, 32'(eshift), 32'd1);
    chk({s, ".ealuc"},  32'(ealuc),  32'(e.aluc));
    chk({s, ".ern0"},   32'(ern0),   32'(e.rn));
    chk({s, ".epc"},    epc,         e.pc);
    chk({s, ".eda"},    eda,         e.da);
    chk({s, ".edb"},    edb,         e.db);
    chk({s, ".epc4"},   epc4,        e.pc + 32'd4);
    chk({s, ".eimm"},   eimm,        x.da ^ x.db);
  endtask

  initial begin
    // stall cancel wreg m2reg wmem mtc0 arith bd mfc0 aluc rn pc da db
    // -> wreg m2reg wmem mtc0 arith bd mfc0 valid aluc rn pc da db
    tv[0]  = '{'{L0,L0,L1,L0,L0,L0,L1,L0,2'b00,4'h0,5'd3,32'h100,32'd5,32'd7},
               '{L1,L0,L0,L0,L1,L0,2'b00,L1,4'h0,5'd3,32'h100,32'd5,32'd7}};
    tv[1]  = '{'{L0,L0,L0,L0,L1,L0,L0,L0,2'b00,4'h0,5'd0,32'h104,32'd8,32'd9},
               '{L0,L0,L1,L0,L0,L0,2'b00,L1,4'h0,5'd0,32'h104,32'd8,32'd9}};
    tv[2]  = '{'{L1,L0,L1,L1,L0,L0,L0,L0,2'b00,4'h0,5'd4,32'h108,32'h10,32'd0},
               '{L0,L0,L0,L0,L0,L0,2'b00,L0,4'h0,5'd4,32'h108,32'h10,32'd0}};
    tv[3]  = tv[2];
    tv[4]  = '{'{L0,L0,L1,L1,L0,L0,L0,L0,2'b00,4'h0,5'd4,32'h108,32'h10,32'd0},
               '{L1,L1,L0,L0,L0,L0,2'b00,L1,4'h0,5'd4,32'h108,32'h10,32'd0}};
    tv[5]  = '{'{L0,L1,L1,L0,L1,L1,L1,L0,2'b10,4'h6,5'd7,32'h200,32'h11,32'h22},
               '{L0,L0,L0,L0,L0,L0,2'b00,L0,4'h6,5'd7,32'h200,32'h11,32'h22}};
    tv[6]  = '{'{L1,L1,L1,L0,L0,L0,L0,L0,2'b00,4'h2,5'd8,32'h204,32'h33,32'h44},
               '{L0,L0,L0,L0,L0,L0,2'b00,L0,4'h2,5'd8,32'h204,32'h33,32'h44}};
    tv[7]  = '{'{L0,L0,L1,L0,L0,L0,L0,L0,2'b00,4'h2,5'd8,32'h204,32'h33,32'h44},
               '{L1,L0,L0,L0,L0,L0,2'b00,L1,4'h2,5'd8,32'h204,32'h33,32'h44}};
    tv[8]  = '{'{L0,L0,L0,L0,L0,L0,L0,L1,2'b00,4'h1,5'd0,32'h1004,32'h1,32'h2},
               '{L0,L0,L0,L0,L0,L1,2'b00,L1,4'h1,5'd0,32'h1004,32'h1,32'h2}};
    tv[9]  = '{'{L0,L1,L0,L0,L0,L0,L0,L1,2'b00,4'h1,5'd0,32'h1008,32'h3,32'h4},
               '{L0,L0,L0,L0,L0,L0,2'b00,L0,4'h1,5'd0,32'h1008,32'h3,32'h4}};
    tv[10] = '{'{L0,L0,L1,L0,L0,L1,L0,L0,2'b11,4'hf,5'd31,32'h300,32'hdead,32'hbeef},
               '{L1,L0,L0,L1,L0,L0,2'b11,L1,4'hf,5'd31,32'h300,32'hdead,32'hbeef}};

    drive_all(1'b0);
    clrn = 1'b0;
    #2;
    chk("rst.ewreg0", 32'(ewreg0), 32'd0);
    chk("rst.evalid", 32'(evalid), 32'd0);
    chk("rst.epc",    epc,         32'h0);
    chk("rst.epc4",   epc4,        32'h0);
    @(negedge clk);
    clrn = 1'b1;

    for (int n = 0; n < 11; n++) begin
      apply(tv[n].i);
      @(posedge clk);
      #1;
      check_vec(n, tv[n].i, tv[n].e);
      @(negedge clk);
    end

    // Load everything with ones, then reset asynchronously mid-cycle.
    drive_all(1'b1);
    @(posedge clk);
    #1;
    chk("ones.evalid", 32'(evalid), 32'd1);
    chk("ones.epc",    epc,         32'hffff_ffff);
    #2;
    clrn = 1'b0;
    #1;
    chk("arst.ewreg0", 32'(ewreg0), 32'd0);
    chk("arst.evalid", 32'(evalid), 32'd0);
    chk("arst.epc",    epc,         32'h0);
    chk("arst.eda",    eda,         32'h0);
    chk("arst.emfc0",  32'(emfc0),  32'd0);
    chk("arst.ern0",   32'(ern0),   32'd0);
    @(negedge clk);
    clrn = 1'b1;
    drive_all(1'b0);
    dpc = 32'h0000_0040;
    drn = 5'd9;
    dwreg = 1'b1;
    @(posedge clk);
    #1;
    chk("rel.epc",    epc,          32'h40);
    chk("rel.ern0",   32'(ern0),    32'd9);
    chk("rel.ewreg0", 32'(ewreg0),  32'd1);
    chk("rel.evalid", 32'(evalid),  32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
